// File: rtl/eth_pkg.sv
// ----------------------------------------------------------------------------
// eth_pkg : shared constants, FSM state type and CRC-32 byte step for eth_rx_frame
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package eth_pkg;

   localparam int ST_CRC_ERR  = 0;
   localparam int ST_RUNT     = 1;
   localparam int ST_LONG     = 2;
   localparam int ST_RX_ER    = 3;
   localparam int ST_MAC_MISS = 4;

   localparam logic [7:0]  PREAMBLE      = 8'h55;
   localparam logic [7:0]  SFD           = 8'hD5;
   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
   localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PRE     = 3'd1,
      S_FRAME   = 3'd2,
      S_EOP     = 3'd3,
      S_DISCARD = 3'd4
   } state_t;

   // Reflected CRC-32: byte enters LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
      end
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/eth_rx_frame_if.sv
// ----------------------------------------------------------------------------
// eth_rx_frame_if : byte stream in from RGMII capture, framed stream/status out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface eth_rx_frame_if;
   logic        in_dv;
   logic        in_er;
   logic [7:0]  in_data;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_sop;
   logic        out_eop;
   logic [4:0]  out_status;
   logic [15:0] ok_cnt;
   logic [15:0] bad_cnt;

   modport master (
      output in_dv, in_er, in_data,
      input  out_valid, out_data, out_sop, out_eop, out_status, ok_cnt, bad_cnt
   );

   modport slave (
      input  in_dv, in_er, in_data,
      output out_valid, out_data, out_sop, out_eop, out_status, ok_cnt, bad_cnt
   );
endinterface

`default_nettype wire

// File: rtl/eth_crc32.sv
// ----------------------------------------------------------------------------
// eth_crc32 : byte-wide reflected CRC-32 register with clear and enable
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module eth_crc32
   import eth_pkg::*;
(
   input  wire logic        rxclk,
   input  wire logic        rstn,
   input  wire logic        clr,
   input  wire logic        en,
   input  wire logic [7:0]  data,
   output logic      [31:0] crc
);

   always_ff @(posedge rxclk or negedge rstn) begin
      if (!rstn) begin
         crc <= CRC_INIT;
      end else if (clr) begin
         crc <= CRC_INIT;
      end else if (en) begin
         crc <= crc32_byte(crc, data);
      end
   end

endmodule

`default_nettype wire

// File: rtl/eth_rx_frame.sv
// ----------------------------------------------------------------------------
// eth_rx_frame : Ethernet RX framer - SFD strip, CRC/length check, FCS strip, status
// Optional DA filter: ETH_RX_MAC_FILTER_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module eth_rx_frame
   import eth_pkg::*;
#(
   parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
   parameter int          MIN_LEN  = 64,
   parameter int          MAX_LEN  = 1518
) (
   input  wire logic     rxclk,
   input  wire logic     rstn,
   eth_rx_frame_if.slave rx
);

   localparam logic [15:0] MIN_L = 16'(MIN_LEN);
   localparam logic [15:0] MAX_L = 16'(MAX_LEN);

   state_t          state;
   logic [15:0]     frame_len;
   logic [3:0][7:0] dly;
   logic            rx_er_seen;
   logic            valid_q;
   logic            sop_q;
   logic            eop_q;
   logic [7:0]      data_q;
   logic [4:0]      status_q;
   logic [15:0]     ok_q;
   logic [15:0]     bad_q;
   logic            sfd_seen;
   logic            byte_in;
   logic [31:0]     crc;
   logic            mac_miss;
   logic [4:0]      status_now;

   assign sfd_seen = rx.in_dv && (rx.in_data == SFD) &&
                     ((state == S_IDLE) || ((state == S_PRE) && !rx.in_er));
   assign byte_in  = (state == S_FRAME) && rx.in_dv;

   eth_crc32 u_crc (
      .rxclk (rxclk),
      .rstn  (rstn),
      .clr   (sfd_seen),
      .en    (byte_in),
      .data  (rx.in_data),
      .crc   (crc)
   );

`ifdef ETH_RX_MAC_FILTER_EN
   logic       ucast_hit;
   logic       bcast_hit;
   logic [2:0] da_idx;
   logic [7:0] da_byte;

   // DA byte 0 is the most significant byte of MAC_ADDR.
   assign da_idx  = 3'd5 - frame_len[2:0];
   assign da_byte = MAC_ADDR[{da_idx, 3'b000} +: 8];

   always_ff @(posedge rxclk or negedge rstn) begin
      if (!rstn) begin
         ucast_hit <= 1'b0;
         bcast_hit <= 1'b0;
      end else if (sfd_seen) begin
         ucast_hit <= 1'b1;
         bcast_hit <= 1'b1;
      end else if (byte_in && (frame_len < 16'd6)) begin
         if (rx.in_data != da_byte) ucast_hit <= 1'b0;
         if (rx.in_data != 8'hFF)   bcast_hit <= 1'b0;
      end
   end

   assign mac_miss = !(ucast_hit || bcast_hit) || (frame_len < 16'd6);
`else
   logic unused_mac_addr;
   assign unused_mac_addr = ^MAC_ADDR;
   assign mac_miss        = 1'b0;
`endif

   always_comb begin
      status_now              = '0;
      status_now[ST_CRC_ERR]  = (crc != CRC_RESIDUE);
      status_now[ST_RUNT]     = (frame_len < MIN_L);
      status_now[ST_LONG]     = (frame_len > MAX_L);
      status_now[ST_RX_ER]    = rx_er_seen;
      status_now[ST_MAC_MISS] = mac_miss;
   end

   always_ff @(posedge rxclk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         frame_len  <= '0;
         dly        <= '0;
         rx_er_seen <= 1'b0;
         valid_q    <= 1'b0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         data_q     <= '0;
         status_q   <= '0;
         ok_q       <= '0;
         bad_q      <= '0;
      end else begin
         valid_q  <= 1'b0;
         sop_q    <= 1'b0;
         eop_q    <= 1'b0;
         status_q <= '0;

         if (sfd_seen) begin
            frame_len  <= '0;
            dly        <= '0;
            rx_er_seen <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (rx.in_dv) begin
                  if (rx.in_data == PREAMBLE) state <= S_PRE;
                  else if (sfd_seen)          state <= S_FRAME;
                  else                        state <= S_DISCARD;
               end
            end

            S_PRE: begin
               if (!rx.in_dv)                                 state <= S_IDLE;
               else if (sfd_seen)                             state <= S_FRAME;
               else if (!rx.in_er && rx.in_data == PREAMBLE)  state <= S_PRE;
               else                                           state <= S_DISCARD;
            end

            S_FRAME: begin
               if (rx.in_dv) begin
                  if (frame_len != 16'hFFFF) frame_len <= frame_len + 16'd1;
                  dly <= {dly[2:0], rx.in_data};
                  if (rx.in_er) rx_er_seen <= 1'b1;
                  // Four bytes of lookahead: the last four bytes (FCS) never leave.
                  if (frame_len >= 16'd4) begin
                     valid_q <= 1'b1;
                     data_q  <= dly[3];
                     sop_q   <= (frame_len == 16'd4);
                  end
               end else begin
                  state <= S_EOP;
               end
            end

            S_EOP: begin
               eop_q    <= 1'b1;
               status_q <= status_now;
               if (status_now == 5'd0) ok_q  <= ok_q + 16'd1;
               else                    bad_q <= bad_q + 16'd1;
               state <= S_IDLE;
            end

            S_DISCARD: begin
               if (!rx.in_dv) state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign rx.out_valid  = valid_q;
   assign rx.out_data   = data_q;
   assign rx.out_sop    = sop_q;
   assign rx.out_eop    = eop_q;
   assign rx.out_status = status_q;
   assign rx.ok_cnt     = ok_q;
   assign rx.bad_cnt    = bad_q;

endmodule

`default_nettype wire
